// File: rtl/inv_exp_pkg.sv
// Shared definitions for the inverse (x/255)^0.3 search: widths, FSM states and the forward table.
// INV_EXP_ROUND_NEAREST_EN adds the ROUND state used for nearest-code rounding.
package inv_exp_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam logic [IN_W-1:0] ONE_Q15 = 16'h8000;

`ifdef INV_EXP_ROUND_NEAREST_EN
  typedef enum logic [1:0] {IDLE, SEARCH, ROUND, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
`endif

  // F[i] is the largest f with (f/2^15)^10 <= (i/255)^3, an exact integer form of
  // floor(2^15 * (i/255)^0.3) that avoids real arithmetic at elaboration.
  function automatic logic [IN_W-1:0] fwd_entry(input int unsigned idx);
    logic [191:0] rhs;
    logic [191:0] lhs;
    logic [191:0] p;
    logic [16:0]  f;
    logic [16:0]  cand;
    rhs = (192'(idx) * 192'(idx) * 192'(idx)) << 150;
    f   = '0;
    for (int b = 16; b >= 0; b--) begin
      cand = f | (17'd1 << b);
      p    = 192'd1;
      for (int k = 0; k < 10; k++) begin
        p = p * 192'(cand);
      end
      lhs = p * 192'd16581375;
      if ((cand <= 17'd32768) && (lhs <= rhs)) begin
        f = cand;
      end
    end
    return f[IN_W-1:0];
  endfunction

endpackage

// File: rtl/inverse_exponent_search_if.sv
// Valid/ready input and output channels of the inverse exponent search block.
interface inverse_exponent_search_if;
  import inv_exp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/pow0p3_rom.sv
// Combinational 256x16 read port holding F[i] = floor(2^15 * (i/255)^0.3).
module pow0p3_rom
  import inv_exp_pkg::*;
(
  input  logic [OUT_W-1:0] addr,
  output logic [IN_W-1:0]  data
);

  logic [IN_W-1:0] rom_table [256];

  for (genvar g = 0; g < 256; g++) begin : g_entry
    localparam logic [IN_W-1:0] ENTRY = fwd_entry(g);
    assign rom_table[g] = ENTRY;
  end

  assign data = rom_table[addr];

endmodule

// File: rtl/inverse_exponent_search.sv
// Recovers the 8-bit code x whose (x/255)^0.3 best matches a 1.15 target by MSB-first search.
// Define INV_EXP_ROUND_NEAREST_EN to add a ROUND cycle that picks the nearer of x and x+1.
module inverse_exponent_search
  import inv_exp_pkg::*;
(
  input logic clk,
  input logic rst_n,
  inverse_exponent_search_if.slave bus
);

  state_t           state;
  logic [IN_W-1:0]  y_q;
  logic [OUT_W-1:0] result;
  logic [2:0]       bit_idx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_sat_q;

  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] next_result;
  logic [OUT_W-1:0] rom_addr;
  logic [IN_W-1:0]  rom_data;
  logic             keep;

  assign cand        = result | (OUT_W'(1) << bit_idx);
  assign keep        = (rom_data <= y_q);
  assign next_result = keep ? cand : result;

`ifdef INV_EXP_ROUND_NEAREST_EN
  logic [OUT_W-1:0] x_up;
  logic [IN_W-1:0]  f_lo;
  logic [IN_W-1:0]  d0;
  logic [IN_W-1:0]  d1;

  // f_lo tracks F[result] during the search, so ROUND only needs the ROM for F[x+1].
  assign x_up     = (result == 8'hFF) ? result : result + 8'd1;
  assign rom_addr = (state == ROUND) ? x_up : cand;
  assign d0       = y_q - f_lo;
  assign d1       = rom_data - y_q;
`else
  assign rom_addr = cand;
`endif

  pow0p3_rom u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      y_q         <= '0;
      result      <= '0;
      bit_idx     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
`ifdef INV_EXP_ROUND_NEAREST_EN
      f_lo        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            y_q        <= bus.in_data;
            result     <= '0;
            bit_idx    <= 3'd7;
            in_ready_q <= 1'b0;
            state      <= SEARCH;
`ifdef INV_EXP_ROUND_NEAREST_EN
            f_lo       <= '0;
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SEARCH: begin
          result  <= next_result;
          bit_idx <= bit_idx - 3'd1;
`ifdef INV_EXP_ROUND_NEAREST_EN
          if (keep) begin
            f_lo <= rom_data;
          end
          if (bit_idx == 3'd0) begin
            state <= ROUND;
          end
`else
          if (bit_idx == 3'd0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= next_result;
            out_sat_q   <= (y_q > ONE_Q15);
          end
`endif
        end
`ifdef INV_EXP_ROUND_NEAREST_EN
        ROUND: begin
          state       <= DONE;
          out_valid_q <= 1'b1;
          out_sat_q   <= (y_q > ONE_Q15);
          // Ties stay on x; the top code has no upper neighbour.
          out_data_q  <= ((result != 8'hFF) && (d1 < d0)) ? x_up : result;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule
